// File: rtl/rvga_pipe_latch.sv
// Generic valid/ready pipeline-stage register with optional two-entry skid buffer.
// Optional stall counter port stall_cnt_o is enabled by defining RVGA_PIPE_PERF_EN.
module rvga_pipe_latch #(
  parameter int unsigned width_p     = 64,
  parameter int unsigned skid_p      = 1,
  parameter int unsigned cnt_width_p = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  input  logic               ready_i,
  output logic [width_p-1:0] data_o
`ifdef RVGA_PIPE_PERF_EN
  ,
  output logic [cnt_width_p-1:0] stall_cnt_o
`endif
);

  logic accept;
  logic emit;

  assign accept = v_i & ready_o;
  assign emit   = v_o & ready_i;

  if (width_p < 1 || cnt_width_p < 1) begin : g_bad_param
    $error("rvga_pipe_latch: width_p and cnt_width_p must be >= 1");
  end

  if (skid_p != 0) begin : g_skid
    typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
    } state_e;

    state_e             state_q;
    state_e             state_d;
    logic [width_p-1:0] main_q;
    logic [width_p-1:0] skid_q;
    logic               load_main;
    logic               main_from_skid;
    logic               load_skid;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q <= EMPTY;
      end else begin
        state_q <= state_d;
      end
    end

    // Flush overrides every transition and suppresses all data loads;
    // an emit in the same cycle has already been taken downstream.
    always_comb begin
      state_d        = state_q;
      load_main      = 1'b0;
      main_from_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush_i) begin
        state_d = EMPTY;
      end else begin
        unique case (state_q)
          EMPTY: begin
            if (accept) begin
              state_d   = ONE;
              load_main = 1'b1;
            end
          end
          ONE: begin
            if (accept && emit) begin
              load_main = 1'b1;
            end else if (accept) begin
              state_d   = FULL;
              load_skid = 1'b1;
            end else if (emit) begin
              state_d = EMPTY;
            end
          end
          FULL: begin
            if (emit) begin
              state_d        = ONE;
              main_from_skid = 1'b1;
            end
          end
          default: state_d = EMPTY;
        endcase
      end
    end

    always_comb begin
      ready_o = (state_q != FULL);
      v_o     = (state_q != EMPTY);
      data_o  = main_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        main_q <= '0;
        skid_q <= '0;
      end else begin
        if (main_from_skid) begin
          main_q <= skid_q;
        end else if (load_main) begin
          main_q <= data_i;
        end
        if (load_skid) begin
          skid_q <= data_i;
        end
      end
    end
  end else begin : g_single
    logic               v_q;
    logic [width_p-1:0] main_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        v_q    <= 1'b0;
        main_q <= '0;
      end else begin
        if (accept && !flush_i) begin
          main_q <= data_i;
        end
        if (flush_i) begin
          v_q <= 1'b0;
        end else if (accept) begin
          v_q <= 1'b1;
        end else if (emit) begin
          v_q <= 1'b0;
        end
      end
    end

    always_comb begin
      ready_o = ~v_q | ready_i;
      v_o     = v_q;
      data_o  = main_q;
    end
  end

`ifdef RVGA_PIPE_PERF_EN
  logic [cnt_width_p-1:0] stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else if (v_o && !ready_i && !(&stall_cnt_q)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_rvga_pipe_latch.sv
// Self-checking bench for rvga_pipe_latch: skid and single-register builds share
// stimulus and are each checked against a queue-based transfer model.
module tb_rvga_pipe_latch;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 3;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         v_in;
  logic [W-1:0] data_in;
  logic         ready_in;

  logic         ready_o1, v_o1;
  logic [W-1:0] data_o1;
  logic         ready_o0, v_o0;
  logic [W-1:0] data_o0;
`ifdef RVGA_PIPE_PERF_EN
  logic [CW-1:0] cnt_o1, cnt_o0;
`endif

  int pass_cnt = 0;
  int tot_cnt  = 0;

  rvga_pipe_latch #(.width_p(W), .skid_p(1), .cnt_width_p(CW)) u_skid (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .v_i(v_in), .ready_o(ready_o1),
    .data_i(data_in), .v_o(v_o1), .ready_i(ready_in), .data_o(data_o1)
`ifdef RVGA_PIPE_PERF_EN
    , .stall_cnt_o(cnt_o1)
`endif
  );

  rvga_pipe_latch #(.width_p(W), .skid_p(0), .cnt_width_p(CW)) u_single (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .v_i(v_in), .ready_o(ready_o0),
    .data_i(data_in), .v_o(v_o0), .ready_i(ready_in), .data_o(data_o0)
`ifdef RVGA_PIPE_PERF_EN
    , .stall_cnt_o(cnt_o0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Model: each stage is a FIFO of held payloads; capacity 2 for skid, 1 for single.
  logic [W-1:0] q1[$];
  logic [W-1:0] q0[$];
  int m_cnt1, m_cnt0;

  function automatic bit rdy1();
    return q1.size() < 2;
  endfunction
  function automatic bit rdy0();
    return (q0.size() == 0) || ready_in;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1.delete(); q0.delete();
      m_cnt1 = 0; m_cnt0 = 0;
    end else begin
      bit e1, a1, e0, a0;
      e1 = (q1.size() > 0) && ready_in;
      a1 = v_in && rdy1();
      e0 = (q0.size() > 0) && ready_in;
      a0 = v_in && rdy0();
      if (q1.size() > 0 && !ready_in && m_cnt1 < (1 << CW) - 1) m_cnt1++;
      if (q0.size() > 0 && !ready_in && m_cnt0 < (1 << CW) - 1) m_cnt0++;
      if (e1) void'(q1.pop_front());
      if (e0) void'(q0.pop_front());
      if (a1) q1.push_back(data_in);
      if (a0) q0.push_back(data_in);
      if (flush) begin
        q1.delete(); q0.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("skid_v", v_o1, q1.size() > 0);
      chk("skid_ready", ready_o1, rdy1());
      if (q1.size() > 0) chk("skid_data", data_o1, q1[0]);
      chk("single_v", v_o0, q0.size() > 0);
      chk("single_ready", ready_o0, rdy0());
      if (q0.size() > 0) chk("single_data", data_o0, q0[0]);
`ifdef RVGA_PIPE_PERF_EN
      chk("skid_cnt", cnt_o1, m_cnt1);
      chk("single_cnt", cnt_o0, m_cnt0);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    v_in = 1'b0; ready_in = 1'b1; flush = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; v_in = 1'b0; data_in = '0; ready_in = 1'b0;
    #1;
    chk("rst_skid_v", v_o1, 1'b0);
    chk("rst_skid_ready", ready_o1, 1'b1);
    chk("rst_skid_data", data_o1, 8'h00);
    chk("rst_single_ready", ready_o0, 1'b1);
    #11 rst_n = 1'b1;
    step();

    // Async reset while FULL, then first transfer behaves as from EMPTY
    ready_in = 1'b0; v_in = 1'b1;
    data_in = 8'h44; step();
    data_in = 8'h55; step();
    chk("full_ready", ready_o1, 1'b0);
    v_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_v", v_o1, 1'b0);
    chk("arst_ready", ready_o1, 1'b1);
    chk("arst_data", data_o1, 8'h00);
    chk("arst_single_v", v_o0, 1'b0);
    v_in = 1'b1; data_in = 8'h05; ready_in = 1'b1;
    @(negedge clk); #2 rst_n = 1'b1;
    step();
    chk("post_rst_data", data_o1, 8'h05);
    chk("post_rst_v", v_o1, 1'b1);
    drain();

    // Streaming
    for (int i = 1; i <= 8; i++) begin
      v_in = 1'b1; ready_in = 1'b1; data_in = W'(i);
      step();
      chk("stream_data", data_o1, i);
      chk("stream_ready", ready_o1, 1'b1);
    end
    drain();

    // Backpressure: A, B taken, C held upstream, then in-order release
    ready_in = 1'b0; v_in = 1'b1;
    data_in = 8'hA1; step();
    data_in = 8'hB2; step();
    chk("bp_ready", ready_o1, 1'b0);
    chk("bp_hold", data_o1, 8'hA1);
    data_in = 8'hC3; step();
    chk("bp_hold2", data_o1, 8'hA1);
    ready_in = 1'b1; step();
    chk("bp_emit_b", data_o1, 8'hB2);
    step();
    chk("bp_emit_c", data_o1, 8'hC3);
    v_in = 1'b0; step();
    chk("bp_empty", v_o1, 1'b0);
    drain();

    // Flush while FULL with a concurrent offer
    ready_in = 1'b0; v_in = 1'b1;
    data_in = 8'h11; step();
    data_in = 8'h22; step();
    data_in = 8'h0D; flush = 1'b1; step();
    chk("flush_v", v_o1, 1'b0);
    chk("flush_ready", ready_o1, 1'b1);
    flush = 1'b0; v_in = 1'b0; ready_in = 1'b1;
    repeat (3) begin
      step();
      chk("flush_nothing", v_o1, 1'b0);
    end

    // Single-register: combinational ready and full throughput
    ready_in = 1'b0; v_in = 1'b1; data_in = 8'h33; step();
    v_in = 1'b0;
    chk("single_stall_ready", ready_o0, 1'b0);
    ready_in = 1'b1; #1;
    chk("single_comb_ready", ready_o0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      v_in = 1'b1; data_in = W'(8'h60 + i);
      step();
      chk("single_tput_v", v_o0, 1'b1);
      chk("single_tput_data", data_o0, 8'h60 + i);
    end
    drain();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      v_in     = ($urandom_range(0, 3) != 0);
      ready_in = ($urandom_range(0, 2) != 0);
      data_in  = W'($urandom);
      flush    = ($urandom_range(0, 19) == 0);
      step();
    end
    drain();

`ifdef RVGA_PIPE_PERF_EN
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    v_in = 1'b1; ready_in = 1'b0; data_in = 8'h01; step();
    v_in = 1'b0;
    repeat (5) step();
    chk("cnt_5", cnt_o1, 3'd5);
    repeat (10) step();
    chk("cnt_sat", cnt_o1, 3'd7);
    flush = 1'b1; step();
    flush = 1'b0;
    chk("cnt_flush", cnt_o1, 3'd7);
    chk("cnt_single", cnt_o0, 3'd7);
    drain();
`endif

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
